step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer_pkg.sv | 26 ++
 rtl/step_timer.sv | 44 ++++
 rtl/step_sequencer.sv | 136 +++++++++++++
 tb/tb_step_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_sequencer_pkg.sv
// Shared types and constants for the eight-step note sequencer.
// Imported by step_sequencer and step_timer.
package step_sequencer_pkg;

    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = 3;
    localparam int NOTE_W    = 12;
    localparam int OCT_W     = 2;
    localparam int TICK_W    = 24;

    typedef enum logic {
        RECORD = 1'b0,
        PLAY   = 1'b1
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] keys;
        logic [OCT_W-1:0]  oct;
    } entry_t;

    // True when exactly one key is pressed.
    function automatic logic is_onehot(input logic [NOTE_W-1:0] v);
        return (v != '0) && ((v & (v - NOTE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step tick counter with wrap pulse and gate-window compare.
// The gate window is evaluated on the value the counter takes this edge.
module step_timer
    import step_sequencer_pkg::*;
#(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int GATE_TICKS     = 9_375_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    input  logic clr_i,
    output logic wrap_o,
    output logic gate_win_o
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [TICK_W-1:0] GATE = TICK_W'(GATE_TICKS);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    // Next tick: cleared on mode change, free-running while playing.
    always_comb begin
        wrap_o = run_i && !clr_i && (tick_q == LAST);
        tick_d = tick_q;
        if (clr_i) begin
            tick_d = '0;
        end else if (run_i) begin
            tick_d = wrap_o ? '0 : tick_q + TICK_W'(1);
        end
        gate_win_o = (tick_d < GATE);
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Eight-step record/playback note sequencer with registered outputs.
// Outputs are computed from next-state values so they align with step_number.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int GATE_TICKS     = 9_375_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play_record,
    input  logic              increment,
    input  logic              decrement,
    input  logic              clear,
    input  logic [NOTE_W-1:0] keys_in,
    input  logic [OCT_W-1:0]  oct_in,
    output logic [NOTE_W-1:0] keys_out,
    output logic [OCT_W-1:0]  oct_out,
    output logic [STEP_W-1:0] step_number,
    output logic              gate,
    output logic              recording
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    entry_t            mem_q [NUM_STEPS];
    entry_t            mem_d [NUM_STEPS];
    logic              inc_q, dec_q;
    logic [NOTE_W-1:0] keys_prev_q;
    logic [NOTE_W-1:0] keys_out_q, keys_out_d;
    logic [OCT_W-1:0]  oct_out_q, oct_out_d;
    logic              gate_q, gate_d;
    logic              rec_q, rec_d;
    logic              trans, run, wrap, gate_win;
    logic              inc_edge, dec_edge, capture;
    entry_t            cur;

    assign state_d  = play_record ? PLAY : RECORD;
    assign trans    = (state_d != state_q);
    assign run      = (state_q == PLAY) && !trans;
    assign inc_edge = increment & ~inc_q;
    assign dec_edge = decrement & ~dec_q;
    assign capture  = (state_q == RECORD) && !trans
                    && (keys_prev_q == '0) && is_onehot(keys_in);

    step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP),
        .GATE_TICKS    (GATE_TICKS)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_i     (run),
        .clr_i     (trans),
        .wrap_o    (wrap),
        .gate_win_o(gate_win)
    );

    // Step movement, capture and clear; capture beats buttons, clear beats capture.
    always_comb begin
        step_d = step_q;
        mem_d  = mem_q;
        if (trans) begin
            step_d = '0;
        end else if (state_q == PLAY) begin
            if (wrap) step_d = step_q + STEP_W'(1);
        end else if (clear) begin
            step_d = '0;
        end else if (capture) begin
            mem_d[step_q] = '{keys: keys_in, oct: oct_in};
            step_d = step_q + STEP_W'(1);
        end else if (inc_edge && !dec_edge) begin
            step_d = step_q + STEP_W'(1);
        end else if (dec_edge && !inc_edge) begin
            step_d = step_q - STEP_W'(1);
        end
        if (clear) begin
            for (int i = 0; i < NUM_STEPS; i++) mem_d[i] = '0;
        end
    end

    // Output selection: live monitor in RECORD, gated entry in PLAY.
    always_comb begin
        cur = mem_d[step_d];
        if (state_d == RECORD) begin
            keys_out_d = keys_in;
            oct_out_d  = oct_in;
            gate_d     = |keys_in;
        end else begin
            gate_d     = gate_win && (cur.keys != '0);
            keys_out_d = gate_d ? cur.keys : '0;
            oct_out_d  = cur.oct;
        end
        rec_d = (state_d == RECORD);
    end

    // Mode FSM, step pointer, edge detectors and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RECORD;
            step_q      <= '0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            keys_prev_q <= '0;
            keys_out_q  <= '0;
            oct_out_q   <= '0;
            gate_q      <= 1'b0;
            rec_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            inc_q       <= increment;
            dec_q       <= decrement;
            keys_prev_q <= keys_in;
            keys_out_q  <= keys_out_d;
            oct_out_q   <= oct_out_d;
            gate_q      <= gate_d;
            rec_q       <= rec_d;
        end
    end

    // Step entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STEPS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STEPS; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign keys_out    = keys_out_q;
    assign oct_out     = oct_out_q;
    assign step_number = step_q;
    assign gate        = gate_q;
    assign recording   = rec_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer with TICKS_PER_STEP=10, GATE_TICKS=6.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play_record = 1'b0;
    logic        increment = 1'b0;
    logic        decrement = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] keys_in = '0;
    logic [1:0]  oct_in = '0;
    logic [11:0] keys_out;
    logic [1:0]  oct_out;
    logic [2:0]  step_number;
    logic        gate;
    logic        recording;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [11:0] k;
        logic [1:0]  o;
        logic        g;
        logic        r;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;
    logic [11:0] mk [8];
    logic [1:0]  mo [8];

    step_sequencer #(
        .TICKS_PER_STEP(10),
        .GATE_TICKS    (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .play_record(play_record),
        .increment  (increment),
        .decrement  (decrement),
        .clear      (clear),
        .keys_in    (keys_in),
        .oct_in     (oct_in),
        .keys_out   (keys_out),
        .oct_out    (oct_out),
        .step_number(step_number),
        .gate       (gate),
        .recording  (recording)
    );

    always #5 clk = ~clk;

    // Monitor: every pending expectation describes the current outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (step_number === e.st && keys_out === e.k && oct_out === e.o
                && gate === e.g && recording === e.r) begin
                passed++;
            end else begin
                $display("FAIL %s @%0t: got step=%0d keys=%h oct=%0d gate=%b rec=%b want step=%0d keys=%h oct=%0d gate=%b rec=%b",
                         e.name, $time, step_number, keys_out, oct_out, gate,
                         recording, e.st, e.k, e.o, e.g, e.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [2:0] s,
                       input logic [11:0] k, input logic [1:0] o,
                       input logic g, input logic r);
        exp_t e;
        e.name = n;
        e.st = s;
        e.k = k;
        e.o = o;
        e.g = g;
        e.r = r;
        sb.push_back(e);
    endtask

    // Expected playback outputs c edges after entering PLAY.
    task automatic exp_play(input string n, input int c);
        int   s;
        int   t;
        logic g;
        s = (c / 10) % 8;
        t = c % 10;
        g = (t < 6) && (mk[s] != 12'h000);
        chk(n, 3'(s), g ? mk[s] : 12'h000, mo[s], g, 1'b0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mk[i] = '0;
            mo[i] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] kv;
        model_clear();
        #3;
        chk("reset", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);

        // Button wrap and hold-without-repeat.
        decrement = 1'b1;
        tick();
        chk("dec_wrap", 3'd7, 12'h000, 2'd0, 1'b0, 1'b1);
        decrement = 1'b0;
        tick();
        chk("dec_rel", 3'd7, 12'h000, 2'd0, 1'b0, 1'b1);
        increment = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("inc_hold", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);
        end
        increment = 1'b0;
        tick();
        chk("inc_rel", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);

        // Capture and advance.
        keys_in = 12'h800;
        oct_in = 2'd1;
        tick();
        chk("cap0", 3'd1, 12'h800, 2'd1, 1'b1, 1'b1);
        keys_in = 12'h000;
        tick();
        chk("rel0", 3'd1, 12'h000, 2'd1, 1'b0, 1'b1);
        keys_in = 12'h004;
        tick();
        chk("cap1", 3'd2, 12'h004, 2'd1, 1'b1, 1'b1);
        keys_in = 12'h000;
        oct_in = 2'd0;
        tick();
        chk("rel1", 3'd2, 12'h000, 2'd0, 1'b0, 1'b1);
        mk[0] = 12'h800;
        mo[0] = 2'd1;
        mk[1] = 12'h004;
        mo[1] = 2'd1;

        // Playback timing across a full cycle and wrap.
        play_record = 1'b1;
        for (int c = 0; c <= 84; c++) begin
            tick();
            exp_play("play", c);
        end
        play_record = 1'b0;
        tick();
        chk("to_rec", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);

        // Collisions: capture beats increment; non-one-hot ignored.
        for (int i = 1; i <= 3; i++) begin
            increment = 1'b1;
            tick();
            chk("inc_step", 3'(i), 12'h000, 2'd0, 1'b0, 1'b1);
            increment = 1'b0;
            tick();
            chk("inc_step_rel", 3'(i), 12'h000, 2'd0, 1'b0, 1'b1);
        end
        increment = 1'b1;
        keys_in = 12'h010;
        oct_in = 2'd2;
        tick();
        chk("coll_cap", 3'd4, 12'h010, 2'd2, 1'b1, 1'b1);
        mk[3] = 12'h010;
        mo[3] = 2'd2;
        increment = 1'b0;
        keys_in = 12'h000;
        tick();
        chk("coll_rel", 3'd4, 12'h000, 2'd2, 1'b0, 1'b1);
        keys_in = 12'h0C0;
        tick();
        chk("non_onehot", 3'd4, 12'h0C0, 2'd2, 1'b1, 1'b1);
        keys_in = 12'h000;
        oct_in = 2'd0;
        tick();
        chk("non_onehot_rel", 3'd4, 12'h000, 2'd0, 1'b0, 1'b1);

        // Clear during PLAY at step 5; step keeps running.
        play_record = 1'b1;
        for (int c = 0; c <= 85; c++) begin
            clear = (c == 53);
            tick();
            if (c == 53) model_clear();
            exp_play("clr_play", c);
        end
        clear = 1'b0;
        play_record = 1'b0;
        tick();
        chk("clr_rec", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);

        // Record steps 0..4, then reset asynchronously mid-playback.
        for (int i = 0; i < 5; i++) begin
            kv = 12'h001 << i;
            keys_in = kv;
            oct_in = 2'(i);
            tick();
            chk("rec5", 3'(i + 1), kv, 2'(i), 1'b1, 1'b1);
            mk[i] = kv;
            mo[i] = 2'(i);
            keys_in = 12'h000;
            tick();
            chk("rec5_rel", 3'(i + 1), 12'h000, 2'(i), 1'b0, 1'b1);
        end
        oct_in = 2'd0;
        play_record = 1'b1;
        for (int c = 0; c <= 42; c++) begin
            tick();
            exp_play("pre_rst", c);
        end
        tick();
        #1;
        reset_n = 1'b0;
        chk("async_rst", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);
        play_record = 1'b0;
        tick();
        chk("rst_hold", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);
        model_clear();
        play_record = 1'b1;
        for (int c = 0; c <= 81; c++) begin
            tick();
            exp_play("post_play", c);
        end
        play_record = 1'b0;
        tick();
        chk("final_rec", 3'd0, 12'h000, 2'd0, 1'b0, 1'b1);

        tick();
        tick();
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
